// File: rtl/clk_mon_pkg.sv
`default_nettype none
// ============================================================================
// Module   : clk_mon_pkg
// Brief    : Shared FSM state type, default gate length and clog2 helper for
//            the clock frequency monitor.
// Revision : 1.0
// ============================================================================
package clk_mon_pkg;

  localparam int unsigned DEFAULT_GATE_CYCLES = 1000;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_SETTLE  = 2'd1,
    ST_MEASURE = 2'd2
  } mon_state_e;

  // Ceiling log2, usable in parameter expressions; clog2(1) == 0.
  function automatic int unsigned clog2(input int unsigned value);
    int unsigned v;
    int unsigned r;
    v = (value > 0) ? value - 1 : 0;
    r = 0;
    while (v > 0) begin
      r = r + 1;
      v = v >> 1;
    end
    return r;
  endfunction

endpackage
`default_nettype wire

// File: rtl/clk_meas_chan.sv
`default_nettype none
// ============================================================================
// Module   : clk_meas_chan
// Brief    : One monitored-clock channel: synchroniser, edge/high counters,
//            published result registers and limit compare.
// Revision : 1.0
// ============================================================================
module clk_meas_chan
  import clk_mon_pkg::*;
#(
  parameter int unsigned CNT_W       = 10,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             mon_clk,
  input  logic             cnt_en,
  input  logic             clear_on_start,
  input  logic             publish,
  input  logic [CNT_W-1:0] exp_min,
  input  logic [CNT_W-1:0] exp_max,
  output logic [CNT_W-1:0] meas_edges,
  output logic [CNT_W-1:0] meas_high,
  output logic             violation
);

  logic [SYNC_STAGES-1:0] sync_q, sync_d;
  logic                   prev_q, prev_d;
  logic [CNT_W-1:0]       edge_cnt_q, edge_cnt_d;
  logic [CNT_W-1:0]       high_cnt_q, high_cnt_d;
  logic [CNT_W-1:0]       edges_pub_q, edges_pub_d;
  logic [CNT_W-1:0]       high_pub_q, high_pub_d;
  logic                   synced;
  logic                   rise;
  logic [CNT_W-1:0]       edge_next;
  logic [CNT_W-1:0]       high_next;

  // Counts cannot reach all-ones for legal clocks; the hold is purely defensive.
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v,
                                                input logic             inc);
    if (inc && (v != {CNT_W{1'b1}})) begin
      return v + CNT_W'(1);
    end
    return v;
  endfunction

  always_comb begin
    synced      = sync_q[SYNC_STAGES-1];
    rise        = synced & ~prev_q;
    sync_d      = {sync_q[SYNC_STAGES-2:0], mon_clk};
    prev_d      = synced;

    // edge_next/high_next include the current cycle's sample, so the value
    // published on the last window cycle covers the whole window.
    edge_next   = sat_inc(edge_cnt_q, cnt_en & rise);
    high_next   = sat_inc(high_cnt_q, cnt_en & synced);
    edge_cnt_d  = clear_on_start ? '0 : edge_next;
    high_cnt_d  = clear_on_start ? '0 : high_next;

    edges_pub_d = publish ? edge_next : edges_pub_q;
    high_pub_d  = publish ? high_next : high_pub_q;
    violation   = (edge_next < exp_min) || (edge_next > exp_max);
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      sync_q      <= '0;
      prev_q      <= 1'b0;
      edge_cnt_q  <= '0;
      high_cnt_q  <= '0;
      edges_pub_q <= '0;
      high_pub_q  <= '0;
    end else begin
      sync_q      <= sync_d;
      prev_q      <= prev_d;
      edge_cnt_q  <= edge_cnt_d;
      high_cnt_q  <= high_cnt_d;
      edges_pub_q <= edges_pub_d;
      high_pub_q  <= high_pub_d;
    end
  end

  assign meas_edges = edges_pub_q;
  assign meas_high  = high_pub_q;

endmodule
`default_nettype wire

// File: rtl/clk_freq_monitor.sv
`default_nettype none
// ============================================================================
// Module   : clk_freq_monitor
// Brief    : Multi-channel gate-window frequency/duty monitor with lock-gated
//            settle/measure FSM and sticky per-channel limit flags.
// Revision : 1.0
// ============================================================================
module clk_freq_monitor
  import clk_mon_pkg::*;
#(
  parameter int unsigned NCH          = 4,
  parameter int unsigned GATE_CYCLES  = DEFAULT_GATE_CYCLES,
  parameter int unsigned CNT_W        = clog2(GATE_CYCLES + 1),
  parameter int unsigned SYNC_STAGES  = 2,
  parameter int unsigned SKIP_WINDOWS = 1
) (
  input  logic                 clk,
  input  logic                 resetn,
  input  logic                 locked,
  input  logic [NCH-1:0]       mon_clk,
  input  logic [NCH*CNT_W-1:0] exp_min,
  input  logic [NCH*CNT_W-1:0] exp_max,
  input  logic                 clear_err,
  output logic [NCH*CNT_W-1:0] meas_edges,
  output logic [NCH*CNT_W-1:0] meas_high,
  output logic                 meas_valid,
  output logic [NCH-1:0]       out_of_range,
  output logic                 measuring
);

  localparam int unsigned       WIN_W     = clog2(GATE_CYCLES + 1);
  localparam int unsigned       SKIP_W    = clog2(SKIP_WINDOWS + 2);
  localparam logic [WIN_W-1:0]  WIN_LAST  = WIN_W'(GATE_CYCLES - 1);
  localparam logic [SKIP_W-1:0] SKIP_LAST =
      SKIP_W'((SKIP_WINDOWS > 0) ? (SKIP_WINDOWS - 1) : 0);

  mon_state_e          state_q, state_d;
  logic [1:0]          lock_sync_q, lock_sync_d;
  logic [WIN_W-1:0]    win_cnt_q, win_cnt_d;
  logic [SKIP_W-1:0]   skip_cnt_q, skip_cnt_d;
  logic                meas_valid_q, meas_valid_d;
  logic [NCH-1:0]      oor_q, oor_d;
  logic                locked_s;
  logic                publish;
  logic                cnt_en;
  logic                cnt_clear;
  logic [NCH-1:0]      viol;

  always_comb begin
    lock_sync_d = {lock_sync_q[0], locked};
    locked_s    = lock_sync_q[1];
  end

  always_comb begin
    state_d    = state_q;
    win_cnt_d  = win_cnt_q;
    skip_cnt_d = skip_cnt_q;
    publish    = 1'b0;

    // Any loss of lock abandons the partial window without publishing.
    if (!locked_s) begin
      state_d    = ST_IDLE;
      win_cnt_d  = '0;
      skip_cnt_d = '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          win_cnt_d  = '0;
          skip_cnt_d = '0;
          state_d    = (SKIP_WINDOWS == 0) ? ST_MEASURE : ST_SETTLE;
        end
        ST_SETTLE: begin
          if (win_cnt_q == WIN_LAST) begin
            win_cnt_d = '0;
            if (skip_cnt_q == SKIP_LAST) begin
              state_d = ST_MEASURE;
            end else begin
              skip_cnt_d = skip_cnt_q + SKIP_W'(1);
            end
          end else begin
            win_cnt_d = win_cnt_q + WIN_W'(1);
          end
        end
        ST_MEASURE: begin
          if (win_cnt_q == WIN_LAST) begin
            win_cnt_d = '0;
            publish   = 1'b1;
          end else begin
            win_cnt_d = win_cnt_q + WIN_W'(1);
          end
        end
        default: begin
          state_d    = ST_IDLE;
          win_cnt_d  = '0;
          skip_cnt_d = '0;
        end
      endcase
    end
  end

  always_comb begin
    cnt_en       = (state_q == ST_MEASURE);
    // Clearing on publish lets the next window's first sample land with no gap.
    cnt_clear    = (state_q != ST_MEASURE) | publish;
    meas_valid_d = publish;
    oor_d        = (oor_q & ~{NCH{clear_err}}) | (publish ? viol : '0);
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q      <= ST_IDLE;
      lock_sync_q  <= '0;
      win_cnt_q    <= '0;
      skip_cnt_q   <= '0;
      meas_valid_q <= 1'b0;
      oor_q        <= '0;
    end else begin
      state_q      <= state_d;
      lock_sync_q  <= lock_sync_d;
      win_cnt_q    <= win_cnt_d;
      skip_cnt_q   <= skip_cnt_d;
      meas_valid_q <= meas_valid_d;
      oor_q        <= oor_d;
    end
  end

  for (genvar ch = 0; ch < NCH; ch++) begin : g_chan
    clk_meas_chan #(
      .CNT_W       (CNT_W),
      .SYNC_STAGES (SYNC_STAGES)
    ) u_chan (
      .clk            (clk),
      .resetn         (resetn),
      .mon_clk        (mon_clk[ch]),
      .cnt_en         (cnt_en),
      .clear_on_start (cnt_clear),
      .publish        (publish),
      .exp_min        (exp_min[ch*CNT_W +: CNT_W]),
      .exp_max        (exp_max[ch*CNT_W +: CNT_W]),
      .meas_edges     (meas_edges[ch*CNT_W +: CNT_W]),
      .meas_high      (meas_high[ch*CNT_W +: CNT_W]),
      .violation      (viol[ch])
    );
  end

  assign meas_valid   = meas_valid_q;
  assign out_of_range = oor_q;
  assign measuring    = (state_q == ST_MEASURE);

endmodule
`default_nettype wire
